sm_stim_sequencer: RTL
======================

// Module: sm_stim_sequencer
// PURPOSE
//  Programmable stimulus sequencer for the small two-input control FSMs (i1/i2 -> o1/o2/err).
//  Holds a table of (i1, i2, hold) steps and resets the target FSM. It then replays the table
//  cycle-accurately into the FSM, monitors the FSM's err, and reports done/fault.
//  Sits between a config master and one FSM instance; owns the FSM's nrst, i1 and i2.
// PARAMETERS
//  DEPTH   16  step-table entries
//  AW      4   table address width, clog2(DEPTH)
//  HOLD_W  4   hold field width; each step is driven for hold+1 cycles
// PORTS
//  clk       in   1         system clock, rising edge
//  nrst      in   1         asynchronous active-low reset
//  cfg_we    in   1         table write strobe; ignored while busy
//  cfg_addr  in   AW        table write address
//  cfg_data  in   HOLD_W+2  entry: {hold[HOLD_W-1:0], i2, i1}
//  cfg_len   in   AW+1      step count; sampled on accepted start; values >DEPTH clamp to DEPTH
//  start     in   1         1-cycle pulse; launches a run
//  abort     in   1         1-cycle pulse; kills the run
//  sm_err    in   1         err output of the target FSM
//  sm_nrst   out  1         reset to the target FSM, active low
//  sm_i1     out  1         stimulus i1 to the target FSM
//  sm_i2     out  1         stimulus i2 to the target FSM
//  busy      out  1         high in RST and RUN
//  done      out  1         level; high in DONE until next accepted start or abort
//  fault     out  1         level; high in FAULT until next accepted start or abort
//  step_idx  out  AW        index of the step currently driven
//  err_cnt   out  8         sm_err-high cycles during RUN; saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE; sm_nrst=1; sm_i1=0; sm_i2=0; busy=0; done=0; fault=0; step_idx=0; err_cnt=0.
//  Table contents are not reset.
//  All outputs are registered.
//  States: IDLE, RST, RUN, DONE, FAULT.
//  IDLE/DONE/FAULT + start + cfg_len!=0 -> RST.
//    On entry: clear done, fault and err_cnt; latch length.
//    start with cfg_len==0 is ignored. start while busy is ignored.
//  RST: sm_nrst=0 for exactly 2 cycles; sm_i1=sm_i2=0; then -> RUN.
//  RUN: drive table[step_idx].{i1,i2} for hold+1 cycles, then step_idx+1.
//    After the last step's final cycle -> DONE, with sm_i1=sm_i2=0.
//  Latency: start sampled at edge N; sm_nrst low for cycles N+1..N+2; step 0 driven from edge N+3.
//  abort in any state -> IDLE at the next edge with reset-value outputs. abort beats a simultaneous start.
//  sm_err is sampled only in RUN. err_cnt increments once per high cycle.
//  cfg_we is honoured only in IDLE/DONE/FAULT; write takes effect at the next edge.
//  nrst low mid-run: immediate async return to the reset values above.
// CONFIGURATION
//  SM_SEQ_ERRSTOP_EN defined:
//    sm_err high in RUN -> FAULT at the next edge; fault=1; sm_i1=sm_i2=0; step_idx frozen.
//    err_cnt still counts that cycle.
//  SM_SEQ_ERRSTOP_EN undefined:
//    FAULT is unreachable; fault is tied 0; err is only counted and the run completes.
// STRUCTURE
//  sm_seq_defs.vh: state encodings (3-bit localparams) and the entry field offsets.
//  Sub-module sm_seq_mem: DEPTH x (HOLD_W+2) register file, sync write, async read.
//  Top holds the FSM, hold counter, step counter and err counter.
// TESTING
//  1. Load (i1,i2,hold) = (1,0,0),(1,1,1),(0,1,0); cfg_len=3; start
//     -> sm_nrst=0 for 2 cycles; {i1,i2}=10 x1, 11 x2, 01 x1; then done=1, busy=0, {i1,i2}=00.
//  2. cfg_len=0 with start -> busy stays 0; no sm_nrst pulse; done unchanged.
//  3. abort while step_idx=1 -> next cycle: IDLE, busy=0, sm_i1=sm_i2=0, done=0.
//     Same test with abort+start together -> stays IDLE.
//  4. sm_err high 1 cycle in step 1
//     -> with SM_SEQ_ERRSTOP_EN: fault=1, busy=0, err_cnt=1;
//     -> without: err_cnt=1, run reaches done=1.
//  5. nrst low mid-RUN -> outputs at reset values immediately, without waiting for a clock edge.
//     Rerun after release replays the table unchanged.
//  6. cfg_we to addr 0 during RUN, then rerun -> original entry 0 still driven.
//     Hold=15 -> step driven 16 cycles.
//     err held high 300 cycles -> err_cnt=255.

Source files
------------

// File: rtl/sm_stim_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sm_stim_sequencer_pkg
// Shared definitions for the stimulus sequencer:
//   - state_t      : 3-bit sequencer state encodings
//   - ENT_I1_BIT   : bit offset of i1 within a table entry
//   - ENT_I2_BIT   : bit offset of i2 within a table entry
//   - ENT_HOLD_LSB : lsb of the hold field within a table entry
// Entry layout is {hold[HOLD_W-1:0], i2, i1}.
// -----------------------------------------------------------------------------
package sm_stim_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int ENT_I1_BIT   = 0;
    localparam int ENT_I2_BIT   = 1;
    localparam int ENT_HOLD_LSB = 2;

endpackage

// File: rtl/sm_stim_sequencer_mem.sv
// -----------------------------------------------------------------------------
// sm_stim_sequencer_mem
// Step table: DEPTH x DW register file, synchronous write, asynchronous read.
// Contents are deliberately not reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module sm_stim_sequencer_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sm_stim_sequencer.sv
// -----------------------------------------------------------------------------
// sm_stim_sequencer
// Programmable stimulus sequencer for a small two-input control FSM. A table of
// (i1, i2, hold) steps is loaded by a config master; start resets the target
// FSM for two cycles and then replays the table, each step held hold+1 cycles.
// The target's err is counted while replaying.
//
// Optional feature macro: SM_SEQ_ERRSTOP_EN
//   defined   : sm_err high while replaying stops the run in FAULT
//   undefined : err is only counted, FAULT is unreachable, fault is always 0
//
// Ports:
//   clk       in   clock, rising edge
//   nrst      in   asynchronous active-low reset
//   cfg_we    in   table write strobe (ignored while busy)
//   cfg_addr  in   table write address
//   cfg_data  in   table entry {hold, i2, i1}
//   cfg_len   in   step count, sampled on an accepted start, clamped to DEPTH
//   start     in   launch pulse
//   abort     in   kill pulse, wins over start
//   sm_err    in   err output of the target FSM
//   sm_nrst   out  reset to the target FSM, active low
//   sm_i1     out  stimulus i1
//   sm_i2     out  stimulus i2
//   busy      out  high while resetting the target or replaying
//   done      out  run completed
//   fault     out  run stopped on err
//   step_idx  out  index of the step being driven
//   err_cnt   out  saturating count of sm_err-high cycles while replaying
// -----------------------------------------------------------------------------
module sm_stim_sequencer
    import sm_stim_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [HOLD_W+1:0] cfg_data,
    input  logic [AW:0]       cfg_len,
    input  logic              start,
    input  logic              abort,
    input  logic              sm_err,
    output logic              sm_nrst,
    output logic              sm_i1,
    output logic              sm_i2,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [AW-1:0]     step_idx,
    output logic [7:0]        err_cnt
);

    localparam int          EW      = HOLD_W + 2;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t              state;
    logic [AW:0]         len;
    logic [1:0]          rst_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   cur_hold;
    logic [AW-1:0]       rd_addr;
    logic [EW-1:0]       rd_data;
    logic                idle_like;
    logic                wr_en;
    logic                last_step;
    logic                hold_done;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
        return (l > DEPTH_L) ? DEPTH_L : l;
    endfunction

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAULT);
    assign wr_en     = cfg_we && idle_like;

    // The single read port looks one step ahead while replaying so the next
    // entry is ready at the edge that ends the current step; outside RUN it
    // points at step 0 for the first load.
    assign rd_addr   = (state == ST_RUN) ? step_idx + 1'b1 : '0;

    assign last_step = ({1'b0, step_idx} == len - 1'b1);
    assign hold_done = (hold_cnt == cur_hold);

    sm_stim_sequencer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (EW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= ST_IDLE;
            sm_nrst  <= 1'b1;
            sm_i1    <= 1'b0;
            sm_i2    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            step_idx <= '0;
            err_cnt  <= '0;
            len      <= '0;
            rst_cnt  <= '0;
            hold_cnt <= '0;
            cur_hold <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            sm_nrst  <= 1'b1;
            sm_i1    <= 1'b0;
            sm_i2    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            step_idx <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    if (start && (cfg_len != '0)) begin
                        state    <= ST_RST;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        fault    <= 1'b0;
                        err_cnt  <= '0;
                        step_idx <= '0;
                        sm_i1    <= 1'b0;
                        sm_i2    <= 1'b0;
                        len      <= clamp_len(cfg_len);
                        rst_cnt  <= '0;
                    end
                end

                // One setup cycle after start, then sm_nrst low for two
                // cycles; step 0 is loaded on the third RST edge.
                ST_RST: begin
                    rst_cnt <= rst_cnt + 2'd1;
                    sm_nrst <= (rst_cnt == 2'd2);
                    if (rst_cnt == 2'd2) begin
                        state    <= ST_RUN;
                        step_idx <= '0;
                        sm_i1    <= rd_data[ENT_I1_BIT];
                        sm_i2    <= rd_data[ENT_I2_BIT];
                        cur_hold <= rd_data[ENT_HOLD_LSB +: HOLD_W];
                        hold_cnt <= '0;
                    end
                end

                ST_RUN: begin
                    if (sm_err) begin
                        err_cnt <= sat_inc8(err_cnt);
                    end
`ifdef SM_SEQ_ERRSTOP_EN
                    if (sm_err) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        sm_i1 <= 1'b0;
                        sm_i2 <= 1'b0;
                    end else
`endif
                    if (hold_done) begin
                        if (last_step) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            sm_i1 <= 1'b0;
                            sm_i2 <= 1'b0;
                        end else begin
                            step_idx <= step_idx + 1'b1;
                            sm_i1    <= rd_data[ENT_I1_BIT];
                            sm_i2    <= rd_data[ENT_I2_BIT];
                            cur_hold <= rd_data[ENT_HOLD_LSB +: HOLD_W];
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
